// File: rtl/motion_pi_ctrl.sv
// Line-follower motion controller: IR pair sequencing through the shared A2D, saturating PI loop, signed motor drive.
// Optional MOTION_INTG_DECIM_EN: integrator updates only on every 4th control cycle.
module motion_pi_ctrl #(
  parameter int N_PAIRS    = 3,
  parameter int RES_W      = 12,
  parameter int OUT_W      = 11,
  parameter int SETTLE_CYC = 4096,
  parameter int GAP_CYC    = 32,
  parameter int I_SHIFT    = 4,
  parameter int BASE_SPD   = 480
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    go,
  input  logic [RES_W-1:0]        A2D_res,
  input  logic                    cnv_cmplt,
  output logic                    strt_cnv,
  output logic [2:0]              chnnl,
  output logic [N_PAIRS-1:0]      IR_en,
  output logic signed [OUT_W-1:0] lft_reg,
  output logic signed [OUT_W-1:0] rht_reg,
  output logic                    upd
);

  // state    | meaning
  // IDLE     | waiting for go
  // SETTLE   | emitter k on, letting the receiver settle
  // CNV_R    | start pulse for right channel 2k
  // WAIT_R   | wait for right result, add weighted
  // GAP      | spacing between right and left conversions
  // CNV_L    | start pulse for left channel 2k+1
  // WAIT_L   | wait for left result, subtract weighted
  // INTG     | clamp error, update integrator
  // PI       | form P+I term
  // OUT      | load motor drive, pulse upd
  typedef enum logic [3:0] {
    S_IDLE, S_SETTLE, S_CNV_R, S_WAIT_R, S_GAP,
    S_CNV_L, S_WAIT_L, S_INTG, S_PI, S_OUT
  } state_t;

  localparam int ACC_W   = RES_W + N_PAIRS + 1;
  localparam int TMR_W   = $clog2((SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC) + 1;
  localparam int OUT_MAX = (1 << (OUT_W - 1)) - 1;
  localparam int OUT_MIN = -(1 << (OUT_W - 1));
  localparam logic [1:0] K_LAST = 2'(N_PAIRS - 1);

  state_t                    r_state;
  logic [1:0]                r_k;
  logic [TMR_W-1:0]          r_tmr;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [11:0]        r_err;
  logic signed [11:0]        r_intgrl;
  logic signed [11:0]        r_pi;
  logic                      r_strt;
  logic [2:0]                r_chnnl;
  logic [N_PAIRS-1:0]        r_ir;
  logic signed [OUT_W-1:0]   r_lft;
  logic signed [OUT_W-1:0]   r_rht;
  logic                      r_upd;
`ifdef MOTION_INTG_DECIM_EN
  logic [1:0]                r_dcnt;
`endif

  function automatic logic signed [11:0] sat12(input logic signed [31:0] v);
    if (v > 32'sd2047)       return 12'sh7ff;
    else if (v < -32'sd2048) return 12'sh800;
    else                     return v[11:0];
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [31:0] v);
    if (v > OUT_MAX)      return OUT_W'(OUT_MAX);
    else if (v < OUT_MIN) return OUT_W'(OUT_MIN);
    else                  return v[OUT_W-1:0];
  endfunction

  logic signed [ACC_W-1:0] w_res_sh;
  logic signed [31:0]      w_acc32, w_err32, w_errq32, w_int32, w_pi32;
  logic signed [11:0]      w_err_n, w_int_n, w_pi_n;
  logic signed [OUT_W-1:0] w_lft_n, w_rht_n;

  // Result is unsigned: zero-extend into the signed accumulator before weighting.
  assign w_res_sh = $signed({{(ACC_W-RES_W){1'b0}}, A2D_res} << r_k);
  assign w_acc32  = {{(32-ACC_W){r_acc[ACC_W-1]}}, r_acc};
  assign w_err_n  = sat12(w_acc32);
  assign w_err32  = {{20{w_err_n[11]}}, w_err_n};
  assign w_int32  = {{20{r_intgrl[11]}}, r_intgrl};
  assign w_int_n  = sat12(w_int32 + (w_err32 >>> I_SHIFT));
  assign w_errq32 = {{20{r_err[11]}}, r_err};
  assign w_pi_n   = sat12(w_errq32 + w_int32);
  assign w_pi32   = {{20{r_pi[11]}}, r_pi};
  assign w_rht_n  = sat_out(BASE_SPD - w_pi32);
  assign w_lft_n  = sat_out(BASE_SPD + w_pi32);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_k      <= '0;
      r_tmr    <= '0;
      r_acc    <= '0;
      r_err    <= '0;
      r_intgrl <= '0;
      r_pi     <= '0;
      r_strt   <= 1'b0;
      r_chnnl  <= '0;
      r_ir     <= '0;
      r_lft    <= '0;
      r_rht    <= '0;
      r_upd    <= 1'b0;
`ifdef MOTION_INTG_DECIM_EN
      r_dcnt   <= '0;
`endif
    end else begin
      r_strt <= 1'b0;
      r_upd  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_k     <= '0;
            r_ir    <= N_PAIRS'(1);
            r_tmr   <= TMR_W'(SETTLE_CYC - 1);
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_tmr == '0) begin
            r_strt  <= 1'b1;
            r_chnnl <= {r_k, 1'b0};
            r_state <= S_CNV_R;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        S_CNV_R: r_state <= S_WAIT_R;
        S_WAIT_R: begin
          if (cnv_cmplt) begin
            r_acc   <= r_acc + w_res_sh;
            r_tmr   <= TMR_W'(GAP_CYC - 1);
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_tmr == '0) begin
            r_strt  <= 1'b1;
            r_chnnl <= {r_k, 1'b1};
            r_state <= S_CNV_L;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        S_CNV_L: r_state <= S_WAIT_L;
        S_WAIT_L: begin
          if (cnv_cmplt) begin
            r_acc <= r_acc - w_res_sh;
            if (r_k == K_LAST) begin
              r_ir    <= '0;
              r_state <= S_INTG;
            end else begin
              r_k     <= r_k + 2'd1;
              r_ir    <= N_PAIRS'(1) << (r_k + 2'd1);
              r_tmr   <= TMR_W'(SETTLE_CYC - 1);
              r_state <= S_SETTLE;
            end
          end
        end
        S_INTG: begin
          r_err <= w_err_n;
`ifdef MOTION_INTG_DECIM_EN
          if (r_dcnt == 2'd0) r_intgrl <= w_int_n;
          r_dcnt <= r_dcnt + 2'd1;
`else
          r_intgrl <= w_int_n;
`endif
          r_state <= S_PI;
        end
        S_PI: begin
          r_pi    <= w_pi_n;
          r_state <= S_OUT;
        end
        S_OUT: begin
          r_rht <= w_rht_n;
          r_lft <= w_lft_n;
          r_upd <= 1'b1;
          r_acc <= '0;
          if (go) begin
            r_k     <= '0;
            r_ir    <= N_PAIRS'(1);
            r_tmr   <= TMR_W'(SETTLE_CYC - 1);
            r_state <= S_SETTLE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign strt_cnv = r_strt;
  assign chnnl    = r_chnnl;
  assign IR_en    = r_ir;
  assign lft_reg  = r_lft;
  assign rht_reg  = r_rht;
  assign upd      = r_upd;

endmodule

// File: tb/tb_motion_pi_ctrl.sv
// Scoreboard bench for motion_pi_ctrl: A2D responder, protocol monitor and reference model of the control law.
module tb_motion_pi_ctrl;
  localparam int N_PAIRS    = 3;
  localparam int RES_W      = 12;
  localparam int OUT_W      = 11;
  localparam int SETTLE_CYC = 16;
  localparam int GAP_CYC    = 4;
  localparam int I_SHIFT    = 4;
  localparam int BASE_SPD   = 480;
  localparam int N_CH       = 2 * N_PAIRS;
  localparam int OMAX       = (1 << (OUT_W - 1)) - 1;
  localparam int OMIN       = -(1 << (OUT_W - 1));

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    go;
  logic [RES_W-1:0]        A2D_res;
  logic                    cnv_cmplt;
  logic                    strt_cnv;
  logic [2:0]              chnnl;
  logic [N_PAIRS-1:0]      IR_en;
  logic signed [OUT_W-1:0] lft_reg;
  logic signed [OUT_W-1:0] rht_reg;
  logic                    upd;

  motion_pi_ctrl #(
    .N_PAIRS(N_PAIRS), .RES_W(RES_W), .OUT_W(OUT_W), .SETTLE_CYC(SETTLE_CYC),
    .GAP_CYC(GAP_CYC), .I_SHIFT(I_SHIFT), .BASE_SPD(BASE_SPD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .A2D_res(A2D_res), .cnv_cmplt(cnv_cmplt),
    .strt_cnv(strt_cnv), .chnnl(chnnl), .IR_en(IR_en), .lft_reg(lft_reg),
    .rht_reg(rht_reg), .upd(upd)
  );

  always #5 clk = ~clk;

  typedef struct { int lft; int rht; int intg; } exp_t;
  exp_t sb_q[$];
  exp_t sb_e;

  int ch_val[8];
  int m_intg = 0;
  int m_cyc  = 0;
  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int cmplt_r = 0;
  int cmplt_l = 0;
  int strt_count = 0;
  int upd_count  = 0;
  int exp_ch = 0;
  int ir_rise = 0;
  logic [N_PAIRS-1:0] prev_ir = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Reference control law for one full sweep of the current channel values.
  task automatic model_push();
    int   acc;
    int   err;
    int   pi;
    bit   do_int;
    exp_t e;
    acc = 0;
    for (int k = 0; k < N_PAIRS; k++) acc += (ch_val[2*k] - ch_val[2*k+1]) * (1 << k);
    err = clamp(acc, -2048, 2047);
`ifdef MOTION_INTG_DECIM_EN
    do_int = (m_cyc % 4 == 0);
`else
    do_int = 1'b1;
`endif
    if (do_int) m_intg = clamp(m_intg + (err >>> I_SHIFT), -2048, 2047);
    m_cyc++;
    pi = clamp(err + m_intg, -2048, 2047);
    e.rht  = clamp(BASE_SPD - pi, OMIN, OMAX);
    e.lft  = clamp(BASE_SPD + pi, OMIN, OMAX);
    e.intg = m_intg;
    sb_q.push_back(e);
  endtask

  task automatic gen_vals(input int mode);
    int r;
    for (int c = 0; c < N_CH; c++) ch_val[c] = 'h800;
    case (mode)
      1: ch_val[0] = 'h900;
      2: begin ch_val[4] = 'hFFF; ch_val[5] = 0; end
      3: begin
        r = int'($urandom_range(0, 3));
        for (int c = 0; c < N_CH; c++)
          ch_val[c] = (r == 0) ? int'($urandom_range(0, 4095))
                               : 'h800 + int'($urandom_range(0, 400)) - 200;
      end
      default: ;
    endcase
  endtask

  // A2D responder: random latency, sometimes raising cnv_cmplt before the DUT reaches its wait state.
  initial begin
    int ch;
    int d;
    cnv_cmplt = 1'b0;
    A2D_res   = '0;
    forever begin
      @(negedge clk);
      if (rst_n && strt_cnv) begin
        ch = int'(chnnl);
        A2D_res = RES_W'(ch_val[ch]);
        if ($urandom_range(0, 3) == 0) begin
          cnv_cmplt = 1'b1;
          if (ch[0]) cmplt_l = cyc + 2; else cmplt_r = cyc + 2;
          @(negedge clk);
          @(negedge clk);
          cnv_cmplt = 1'b0;
        end else begin
          d = int'($urandom_range(1, 4));
          repeat (d) @(negedge clk);
          cnv_cmplt = 1'b1;
          if (ch[0]) cmplt_l = cyc + 1; else cmplt_r = cyc + 1;
          @(negedge clk);
          cnv_cmplt = 1'b0;
        end
      end
    end
  end

  // Protocol monitor: channel order, emitter one-hot, settle/gap spacing, upd latency.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_ch  = 0;
      prev_ir = '0;
    end else begin
      if (IR_en != prev_ir) begin
        if (IR_en != '0) begin
          check("ir_onehot", int'(IR_en), 1 << (exp_ch / 2));
          ir_rise = cyc;
        end
        prev_ir = IR_en;
      end
      if (strt_cnv) begin
        strt_count++;
        check("chnnl_order", int'(chnnl), exp_ch);
        check("ir_at_strt", int'(IR_en), 1 << (chnnl >> 1));
        if (chnnl[0] == 1'b0) check("settle_cyc", cyc - ir_rise, SETTLE_CYC);
        else                  check("gap_cyc", cyc - cmplt_r, GAP_CYC);
        exp_ch = (exp_ch + 1) % N_CH;
      end
      if (upd) begin
        upd_count++;
        check("upd_latency", cyc - cmplt_l, 3);
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    int a;
    if (rst_n && upd) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_upd: got upd with empty scoreboard, required none (t=%0t)", $time);
      end else begin
        sb_e = sb_q.pop_front();
        check("lft_reg", int'(lft_reg), sb_e.lft);
        check("rht_reg", int'(rht_reg), sb_e.rht);
        a = dut.r_intgrl;
        check("intgrl", a, sb_e.intg);
      end
    end
  end

  task automatic wait_upd();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!upd && n < 1500);
    check("upd_seen", int'(upd), 1);
  endtask

  task automatic wait_ir();
    int n;
    n = 0;
    while (IR_en == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic idle_check();
    int s;
    s = strt_count;
    repeat (60) @(negedge clk);
    check("idle_no_strt", strt_count - s, 0);
    check("idle_ir", int'(IR_en), 0);
  endtask

  task automatic run_phase(input int n, input int mode);
    go = 1'b1;
    for (int i = 0; i < n; i++) begin
      gen_vals(mode);
      model_push();
      if (i == n - 1) begin
        wait_ir();
        go = 1'b0;
      end
      wait_upd();
    end
    idle_check();
  endtask

  initial begin
    int n;
    int u0;
    int a;
    rst_n = 1'b1;
    go    = 1'b0;
    for (int c = 0; c < 8; c++) ch_val[c] = 'h800;
    #2 rst_n = 1'b0;
    #1;
    check("rst_lft", int'(lft_reg), 0);
    check("rst_rht", int'(rht_reg), 0);
    check("rst_ir", int'(IR_en), 0);
    check("rst_strt", int'(strt_cnv), 0);
    check("rst_chnnl", int'(chnnl), 0);
    check("rst_upd", int'(upd), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_phase(1, 0);
    run_phase(2, 1);
    run_phase(1, 2);

    // go dropped while pair 1 right conversion is pending
    go = 1'b1;
    gen_vals(3);
    model_push();
    n = 0;
    do begin @(negedge clk); n++; end while (!(strt_cnv && chnnl == 3'd2) && n < 1000);
    @(negedge clk);
    go = 1'b0;
    wait_upd();
    idle_check();

    run_phase(20, 3);

    // reset asserted asynchronously in the gap after the first right conversion
    gen_vals(3);
    go = 1'b1;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!cnv_cmplt && n < 1000);
    do begin @(negedge clk); #1; n++; end while (cnv_cmplt && n < 1000);
    u0 = upd_count;
    #1 rst_n = 1'b0;
    go = 1'b0;
    #1;
    check("async_lft", int'(lft_reg), 0);
    check("async_rht", int'(rht_reg), 0);
    check("async_ir", int'(IR_en), 0);
    check("async_strt", int'(strt_cnv), 0);
    check("async_upd", int'(upd), 0);
    a = dut.r_intgrl;
    check("async_intgrl", a, 0);
    m_intg = 0;
    m_cyc  = 0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_upd", upd_count - u0, 0);

    run_phase(1, 0);
    run_phase(1, 1);

    repeat (10) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/motion_pi_ctrl.md
Name: motion_pi_ctrl

Overview:
- Parametrised next-generation line-follower motion controller.
- Sequences N_PAIRS IR emitter/receiver pairs through the shared A2D and forms a weighted left/right error.
- Runs a saturating PI loop and drives signed left/right motor drive registers to the PWM/motor block.
- Adds a configurable pair count, widths, gains, settle timing, full saturation and an update strobe.

Parameters:
N_PAIRS, 3, IR sensor pairs (1..4); pair k uses chnnl 2k (right) and 2k+1 (left), weight 2^k
RES_W, 12, A2D result width (unsigned)
OUT_W, 11, signed width of lft_reg/rht_reg
SETTLE_CYC, 4096, cycles from IR_en[k] rising to the right-channel strt_cnv
GAP_CYC, 32, cycles from right cnv_cmplt to the left-channel strt_cnv
I_SHIFT, 4, integrator gain: err arithmetic-shifted right by I_SHIFT
BASE_SPD, 480, signed forward-speed offset

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active low
go  input  1  level; high = run control loop continuously
A2D_res  input  RES_W  conversion result, valid when cnv_cmplt=1
cnv_cmplt  input  1  A2D done, level, sampled only in wait states
strt_cnv  output  1  one-cycle conversion start pulse
chnnl  output  3  A2D channel select
IR_en  output  N_PAIRS  one-hot IR emitter enables
lft_reg  output  OUT_W  signed left motor drive
rht_reg  output  OUT_W  signed right motor drive
upd  output  1  one-cycle pulse on the edge lft_reg/rht_reg load

Behaviour:
- Reset (async, rst_n low) values:
  - lft_reg=0, rht_reg=0, IR_en=0, strt_cnv=0, chnnl=0, upd=0.
  - Accumulator, integrator, timer and pair index cleared; state IDLE.
  - Reset mid-operation aborts the cycle with no register update.
- States:
  - IDLE: go=1 goes to SETTLE, k=0.
  - SETTLE: IR_en=1<<k; count SETTLE_CYC cycles, then go to CNV_R.
  - CNV_R: pulse strt_cnv, chnnl=2k; go to WAIT_R.
  - WAIT_R: on cnv_cmplt, acc += zext(A2D_res)<<k; go to GAP.
  - GAP: count GAP_CYC cycles, then go to CNV_L.
  - CNV_L: pulse strt_cnv, chnnl=2k+1; go to WAIT_L.
  - WAIT_L: on cnv_cmplt, acc -= zext(A2D_res)<<k. If k<N_PAIRS-1, k++ and go to SETTLE; else go to INTG.
  - INTG: err = sat12(acc); intgrl = sat12(intgrl + (err>>>I_SHIFT)).
  - PI: pi = sat12(err + intgrl).
  - OUT: rht_reg = satOUT(BASE_SPD - pi), lft_reg = satOUT(BASE_SPD + pi); upd=1; acc cleared. If go=1, go to SETTLE with k=0; else go to IDLE.
- IR_en changes only on the SETTLE entry edge and is all-zero outside SETTLE..WAIT_L.
- chnnl is held stable from the strt_cnv pulse until the matching cnv_cmplt.
- Arithmetic:
  - acc is signed, RES_W+N_PAIRS+1 bits, so it never overflows.
  - sat12 clamps to [-2048, 2047]; satOUT clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - All intermediates are wide enough to avoid wrap before the clamp.
- Integrator persists across cycles; cleared only by reset.
- go deasserted mid-cycle: the current cycle completes, registers and upd update, then IDLE.
- cnv_cmplt outside WAIT_R/WAIT_L is ignored. cnv_cmplt already high on entry to a wait state is consumed immediately.
- Latency from the last cnv_cmplt to upd: exactly 3 clocks (INTG, PI, OUT).

Optional Feature:
- Macro MOTION_INTG_DECIM_EN.
- Defined: a 2-bit cycle counter allows the integrator update only on every 4th control cycle, starting with the first after reset. Other cycles hold intgrl; P path unchanged.
- Undefined: integrator updates every control cycle as above.

Test Plan:
- Default params with SETTLE_CYC=16, GAP_CYC=4; all channels return 0x800; go=1 -> after the first upd, lft_reg=rht_reg=0x1E0 (480), intgrl=0.
- Pair0 R=0x900, L=0x800, others equal -> first cycle err=256, intgrl=16, rht_reg=208, lft_reg=752; second cycle intgrl=32, rht_reg=192, lft_reg=768.
- Pair2 R=0xFFF, L=0x000, others equal -> acc=16380, err sat 2047, pi sat 2047, rht_reg=0x400 (-1024), lft_reg=0x3FF (1023).
- Protocol checks:
  - Monitor strt_cnv/chnnl/IR_en sequence: chnnl order 0,1,2,3,4,5 per cycle.
  - Exactly one IR_en bit high per pair.
  - Right strt_cnv exactly SETTLE_CYC cycles after IR_en rises.
  - upd 3 clocks after the last cnv_cmplt.
- Drop go during pair1 WAIT_R -> cycle completes, one upd, then IDLE with no further strt_cnv. Assert rst_n low mid-GAP -> all outputs 0 asynchronously and no upd.
- With MOTION_INTG_DECIM_EN and the err=256 stimulus over 5 cycles -> intgrl sequence 16,16,16,16,32.
